gpio_bus_arbiter: RTL and testbench

GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

---
 rtl/gpio_bus_pkg.sv | 18 +
 rtl/gpio_bus_arbiter_rr_arb2.sv | 17 +
 rtl/gpio_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the two-master GPIO bus arbiter.
package gpio_bus_pkg;

    localparam int unsigned BUS_W     = 32;
    localparam int unsigned STRB_W    = 4;
    localparam int unsigned BUS_REQ_W = 2;

    localparam logic [BUS_W-1:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam logic [BUS_W-1:0] DEF_ADDR_MASK = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        ACK     = 2'd3
    } state_t;

endpackage

// File: rtl/gpio_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the master not granted last wins.
module rr_arb2
    import gpio_bus_pkg::*;
(
    input  logic [BUS_REQ_W-1:0] pending_i,
    input  logic                 last_i,
    output logic [BUS_REQ_W-1:0] grant_o
);

    always_comb begin
        grant_o = pending_i;
        if (pending_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Arbitrates two masters onto a single GPIO slave, one unpipelined access per grant.
module gpio_bus_arbiter
    import gpio_bus_pkg::*;
#(
    parameter logic [BUS_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [BUS_W-1:0] ADDR_MASK = DEF_ADDR_MASK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  m0_addr,
    input  logic [BUS_W-1:0]  m1_addr,
    input  logic [BUS_W-1:0]  m0_wdata,
    input  logic [BUS_W-1:0]  m1_wdata,
    input  logic              m0_rd,
    input  logic              m1_rd,
    input  logic [STRB_W-1:0] m0_wr,
    input  logic [STRB_W-1:0] m1_wr,
    output logic [BUS_W-1:0]  m0_rdata,
    output logic [BUS_W-1:0]  m1_rdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_err,
    output logic              m1_err,
    output logic [BUS_W-1:0]  s_addr,
    output logic [BUS_W-1:0]  s_wdata,
    output logic              s_rd,
    output logic [STRB_W-1:0] s_wr,
    input  logic [BUS_W-1:0]  s_rdata
);

    state_t                 state_q;
    logic                   gnt_q;
    logic                   last_q;
    logic                   rd_q;
    logic [BUS_W-1:0]       s_addr_q;
    logic [BUS_W-1:0]       s_wdata_q;
    logic                   s_rd_q;
    logic [STRB_W-1:0]      s_wr_q;
    logic [BUS_REQ_W-1:0]   ack_q;
    logic [BUS_REQ_W-1:0]   err_q;
    logic [BUS_W-1:0]       rdata0_q;
    logic [BUS_W-1:0]       rdata1_q;

    logic [BUS_REQ_W-1:0]   pending;
    logic [BUS_REQ_W-1:0]   grant;
    logic [BUS_W-1:0]       addr_d;
    logic [BUS_W-1:0]       wdata_d;
    logic                   rd_d;
    logic [STRB_W-1:0]      wr_d;
    logic                   in_win;

    assign pending = {m1_rd | (|m1_wr), m0_rd | (|m0_wr)};

    rr_arb2 u_rr_arb2 (
        .pending_i (pending),
        .last_i    (last_q),
        .grant_o   (grant)
    );

    // A request with both rd and wr set is carried as a pure read.
    always_comb begin
        addr_d  = grant[1] ? m1_addr  : m0_addr;
        wdata_d = grant[1] ? m1_wdata : m0_wdata;
        rd_d    = grant[1] ? m1_rd    : m0_rd;
        wr_d    = rd_d ? '0 : (grant[1] ? m1_wr : m0_wr);
        in_win  = (addr_d & ADDR_MASK) == BASE_ADDR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            rd_q      <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_rd_q    <= 1'b0;
            s_wr_q    <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            s_rd_q   <= 1'b0;
            s_wr_q   <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|pending) begin
                        gnt_q <= grant[1];
                        rd_q  <= rd_d;
                        if (in_win) begin
                            state_q   <= ISSUE;
                            s_addr_q  <= addr_d;
                            s_wdata_q <= wdata_d;
                            s_rd_q    <= rd_d;
                            s_wr_q    <= wr_d;
                        end else begin
                            state_q         <= ACK;
                            ack_q[grant[1]] <= 1'b1;
                            err_q[grant[1]] <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (rd_q) begin
                        state_q <= WAIT_RD;
                    end else begin
                        state_q      <= ACK;
                        ack_q[gnt_q] <= 1'b1;
                    end
                end
                WAIT_RD: begin
                    state_q      <= ACK;
                    ack_q[gnt_q] <= 1'b1;
                    if (gnt_q) rdata1_q <= s_rdata;
                    else       rdata0_q <= s_rdata;
                end
                ACK: begin
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_rd     = s_rd_q;
    assign s_wr     = s_wr_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench: directed and random transactions against a transaction-level model.
module tb_gpio_bus_arbiter;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        rd;
        logic [3:0]  wr;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_rd, m1_rd;
    logic [3:0]  m0_wr, m1_wr;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_rd;
    logic [3:0]  s_wr;

    int          checks = 0;
    int          errors = 0;
    int          last_m;
    logic [31:0] exp_mem [4];
    logic [31:0] slv_mem [4];
    acc_t        exp_q [$];
    acc_t        obs_q [$];

    always #5 clk = ~clk;

    gpio_bus_arbiter #(.BASE_ADDR(BASE), .ADDR_MASK(MASK)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rd(m0_rd), .m1_rd(m1_rd),
        .m0_wr(m0_wr), .m1_wr(m1_wr),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_err(m0_err), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rd(s_rd), .s_wr(s_wr),
        .s_rdata(s_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Slave with registered read data, one cycle after s_rd.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) slv_mem[i] <= 32'hC0DE_0000 + i;
            s_rdata <= '0;
        end else begin
            if (s_wr != 4'h0) slv_mem[s_addr[3:2]] <= merge(slv_mem[s_addr[3:2]], s_wdata, s_wr);
            if (s_rd) s_rdata <= slv_mem[s_addr[3:2]];
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        acc_t o;
        @(negedge clk);
        if (s_rd || s_wr != 4'h0) begin
            check("strobe_overlap", {71'd0, s_rd && (s_wr != 4'h0)}, 72'd0);
            o.a  = s_addr;
            o.d  = (s_wr != 4'h0) ? s_wdata : 32'h0;
            o.rd = s_rd;
            o.wr = s_wr;
            obs_q.push_back(o);
        end
    endtask

    task automatic compare_acc();
        check("acc_count", 72'(obs_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("acc_entry", 72'(obs_q[i]), 72'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        m0_rd = 1'b0; m0_wr = 4'h0; m1_rd = 1'b0; m1_wr = 4'h0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        check("rst_s_rd", 72'(s_rd), 72'd0);
        check("rst_s_wr", 72'(s_wr), 72'd0);
        check("rst_s_addr", 72'(s_addr), 72'd0);
        check("rst_s_wdata", 72'(s_wdata), 72'd0);
        check("rst_acks", 72'({m0_ack, m1_ack}), 72'd0);
        check("rst_errs", 72'({m0_err, m1_err}), 72'd0);
        check("rst_rdata0", 72'(m0_rdata), 72'd0);
        check("rst_rdata1", 72'(m1_rdata), 72'd0);
        rst = 1'b0;
        last_m = 1;
        for (int i = 0; i < 4; i++) exp_mem[i] = 32'hC0DE_0000 + i;
    endtask

    task automatic do_txn(input logic [31:0] a0, input logic [31:0] d0, input logic r0,
                          input logic [3:0] w0, input logic [31:0] a1, input logic [31:0] d1,
                          input logic r1, input logic [3:0] w1);
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic        r [2];
        logic [3:0]  w [2];
        bit          p [2];
        int          exp_n [2];
        logic [31:0] exp_rdata [2];
        logic        exp_err [2];
        int          order [$];
        int          t, m, lat;
        acc_t        e;
        a[0] = a0; d[0] = d0; r[0] = r0; w[0] = w0;
        a[1] = a1; d[1] = d1; r[1] = r1; w[1] = w1;
        for (int k = 0; k < 2; k++) begin
            p[k] = r[k] || (w[k] != 4'h0);
            exp_n[k] = 0; exp_rdata[k] = '0; exp_err[k] = 1'b0;
        end
        if (p[0] && p[1]) order = (last_m == 0) ? '{1, 0} : '{0, 1};
        else if (p[0])    order = '{0};
        else if (p[1])    order = '{1};
        t = 0;
        foreach (order[k]) begin
            m = order[k];
            if ((a[m] & MASK) != BASE) begin
                lat = 1; exp_err[m] = 1'b1;
            end else if (r[m]) begin
                lat = 3; exp_rdata[m] = exp_mem[a[m][3:2]];
                e.a = a[m]; e.d = 32'h0; e.rd = 1'b1; e.wr = 4'h0;
                exp_q.push_back(e);
            end else begin
                lat = 2; exp_mem[a[m][3:2]] = merge(exp_mem[a[m][3:2]], d[m], w[m]);
                e.a = a[m]; e.d = d[m]; e.rd = 1'b0; e.wr = w[m];
                exp_q.push_back(e);
            end
            t = (k == 0) ? lat : t + 1 + lat;
            exp_n[m] = t;
            last_m = m;
        end
        tick();
        m0_addr = a0; m0_wdata = d0; m0_rd = r0; m0_wr = w0;
        m1_addr = a1; m1_wdata = d1; m1_rd = r1; m1_wr = w1;
        for (int n = 1; n <= t; n++) begin
            tick();
            check("m0_ack", 72'(m0_ack), 72'(p[0] && n == exp_n[0]));
            check("m1_ack", 72'(m1_ack), 72'(p[1] && n == exp_n[1]));
            if (p[0] && n == exp_n[0]) begin
                check("m0_rdata", 72'(m0_rdata), 72'(exp_rdata[0]));
                check("m0_err", 72'(m0_err), 72'(exp_err[0]));
                check("m1_idle_out", 72'({m1_err, m1_rdata}), 72'd0);
                m0_rd = 1'b0; m0_wr = 4'h0;
            end
            if (p[1] && n == exp_n[1]) begin
                check("m1_rdata", 72'(m1_rdata), 72'(exp_rdata[1]));
                check("m1_err", 72'(m1_err), 72'(exp_err[1]));
                check("m0_idle_out", 72'({m0_err, m0_rdata}), 72'd0);
                m1_rd = 1'b0; m1_wr = 4'h0;
            end
        end
        idle_inputs();
        compare_acc();
    endtask

    initial begin
        acc_t e;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        idle_inputs();
        rst = 1'b1;
        tick();
        apply_reset();

        // m0 write, then m1 reads it back
        do_txn(BASE, 32'h0000_00A5, 1'b0, 4'hF, '0, '0, 1'b0, 4'h0);
        do_txn('0, '0, 1'b0, 4'h0, BASE, '0, 1'b1, 4'h0);

        // simultaneous writes from reset, then read back the surviving value
        apply_reset();
        do_txn(BASE, 32'h11, 1'b0, 4'hF, BASE, 32'h22, 1'b0, 4'hF);
        do_txn(BASE, '0, 1'b1, 4'h0, '0, '0, 1'b0, 4'h0);

        // m0 keeps requesting, m1 joins once: m1 goes before m0's next access
        do_txn(BASE + 4, 32'hAAAA_0001, 1'b0, 4'h3, '0, '0, 1'b0, 4'h0);
        do_txn(BASE + 4, 32'hAAAA_0002, 1'b0, 4'hF, BASE + 8, '0, 1'b1, 4'h0);
        do_txn(BASE + 4, '0, 1'b1, 4'h0, '0, '0, 1'b0, 4'h0);

        // out-of-window read and a combined rd+wr request
        do_txn(32'h2000_0000, '0, 1'b1, 4'h0, '0, '0, 1'b0, 4'h0);
        do_txn('0, '0, 1'b0, 4'h0, BASE + 12, 32'hDEAD_BEEF, 1'b1, 4'hF);

        // reset while waiting for read data aborts the transaction
        tick();
        m0_addr = BASE; m0_rd = 1'b1;
        tick();
        tick();
        m0_rd = 1'b0;
        apply_reset();
        e.a = BASE; e.d = 32'h0; e.rd = 1'b1; e.wr = 4'h0;
        exp_q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_ack", 72'({m0_ack, m1_ack}), 72'd0);
        end
        compare_acc();
        do_txn('0, '0, 1'b0, 4'h0, BASE, '0, 1'b1, 4'h0);

        for (int it = 0; it < 40; it++) begin
            logic [31:0] ra [2];
            logic [31:0] rd_ [2];
            logic        rr [2];
            logic [3:0]  rw [2];
            int          use_m;
            use_m = int'($urandom_range(0, 2));
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 4) == 0) ra[k] = BASE ^ (32'h1 << $urandom_range(4, 31));
                else                           ra[k] = BASE | ($urandom_range(0, 3) << 2);
                rd_[k] = $urandom;
                case ($urandom_range(0, 2))
                    0:       begin rr[k] = 1'b1; rw[k] = 4'h0; end
                    1:       begin rr[k] = 1'b0; rw[k] = 4'($urandom_range(1, 15)); end
                    default: begin rr[k] = 1'b1; rw[k] = 4'($urandom_range(1, 15)); end
                endcase
                if (!(use_m == 2 || use_m == k)) begin rr[k] = 1'b0; rw[k] = 4'h0; end
            end
            do_txn(ra[0], rd_[0], rr[0], rw[0], ra[1], rd_[1], rr[1], rw[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
